mem_stage: RTL

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_pkg.sv | 35 +++
 rtl/load_formatter.sv | 34 +++
 rtl/mem_stage.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared MEM-stage definitions: FSM state encoding, funct3 load/store codes,
// mem_control / wb_control bit layout and fixed bus widths.
package pipeline_pkg;

    localparam int unsigned XLEN       = 64;
    localparam int unsigned MEM_CTRL_W = 5;
    localparam int unsigned WB_CTRL_W  = 2;
    localparam int unsigned STRB_W     = 8;

    // mem_control = {mem_read, mem_write, funct3[2:0]}
    localparam int unsigned MC_READ_BIT  = 4;
    localparam int unsigned MC_WRITE_BIT = 3;

    localparam logic [2:0] F3_LB      = 3'b000;
    localparam logic [2:0] F3_LH      = 3'b001;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_LD      = 3'b011;
    localparam logic [2:0] F3_LBU     = 3'b100;
    localparam logic [2:0] F3_LHU     = 3'b101;
    localparam logic [2:0] F3_LWU     = 3'b110;
    localparam logic [2:0] F3_INVALID = 3'b111;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/load_formatter.sv
// Combinational load formatter: extracts the addressed byte lane(s) from an
// aligned doubleword and sign/zero-extends according to funct3.
//   resp_data : aligned doubleword from memory
//   offset    : byte offset within the doubleword (addr[2:0])
//   funct3    : load type
//   result    : register-ready 64-bit value (0 for the invalid code)
module load_formatter
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = XLEN
) (
    input  logic [DATA_WIDTH-1:0] resp_data,
    input  logic [2:0]            offset,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] result
);

    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted = resp_data >> {offset, 3'b000};
        case (funct3)
            F3_LB:   result = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   result = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            F3_LW:   result = {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            F3_LD:   result = shifted;
            F3_LBU:  result = DATA_WIDTH'(shifted[7:0]);
            F3_LHU:  result = DATA_WIDTH'(shifted[15:0]);
            F3_LWU:  result = DATA_WIDTH'(shifted[31:0]);
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: passes non-memory instructions straight through and runs
// loads/stores over a valid/ready request + response-pulse memory bus,
// stalling upstream until the access completes.
//   clk, reset                       : clock, async active-high reset
//   valid_in, alu_in, store_data_in,
//   dest_in, mem_control_in,
//   wb_control_in                    : EX/MEM slot
//   req_*                            : memory request (aligned address, lane data/strobes)
//   resp_valid, resp_data            : memory response pulse
//   stall_out, misalign_out          : upstream hold, misaligned-access pulse
//   alu_out, mem_data_out, dest_out,
//   wb_control_out                   : values to MEM/WB
module mem_stage
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned REG_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid_in,
    input  logic [DATA_WIDTH-1:0]   alu_in,
    input  logic [DATA_WIDTH-1:0]   store_data_in,
    input  logic [REG_ID_WIDTH-1:0] dest_in,
    input  logic [MEM_CTRL_W-1:0]   mem_control_in,
    input  logic [WB_CTRL_W-1:0]    wb_control_in,
    output logic                    req_valid,
    input  logic                    req_ready,
    output logic [DATA_WIDTH-1:0]   req_addr,
    output logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    req_write,
    output logic [STRB_W-1:0]       req_wstrb,
    input  logic                    resp_valid,
    input  logic [DATA_WIDTH-1:0]   resp_data,
    output logic                    stall_out,
    output logic                    misalign_out,
    output logic [DATA_WIDTH-1:0]   alu_out,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    output logic [REG_ID_WIDTH-1:0] dest_out,
    output logic [WB_CTRL_W-1:0]    wb_control_out
);

    mem_state_t            state;
    logic [2:0]            funct3_q;
    logic [2:0]            offset_q;
    logic [DATA_WIDTH-1:0] load_data_q;
    logic [DATA_WIDTH-1:0] fmt_data;

    logic                  mem_read;
    logic                  mem_write;
    logic                  is_mem_op;
    logic                  access_fault;
    logic [2:0]            funct3;
    logic [2:0]            offset;
    logic                  addr_misaligned;
    logic [STRB_W-1:0]     size_strb;
    logic [DATA_WIDTH-1:0] size_mask;
    logic [STRB_W-1:0]     wstrb_c;
    logic [DATA_WIDTH-1:0] wdata_c;

    // Decode the incoming slot: alignment, legality and store lane placement.
    always_comb begin
        mem_read  = mem_control_in[MC_READ_BIT];
        mem_write = mem_control_in[MC_WRITE_BIT];
        funct3    = mem_control_in[2:0];
        offset    = alu_in[2:0];
        is_mem_op = valid_in & (mem_read | mem_write);
        case (funct3[1:0])
            2'd0: begin
                addr_misaligned = 1'b0;
                size_strb       = 8'h01;
                size_mask       = DATA_WIDTH'(64'h0000_0000_0000_00FF);
            end
            2'd1: begin
                addr_misaligned = offset[0];
                size_strb       = 8'h03;
                size_mask       = DATA_WIDTH'(64'h0000_0000_0000_FFFF);
            end
            2'd2: begin
                addr_misaligned = |offset[1:0];
                size_strb       = 8'h0F;
                size_mask       = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF);
            end
            default: begin
                addr_misaligned = |offset;
                size_strb       = 8'hFF;
                size_mask       = DATA_WIDTH'(64'hFFFF_FFFF_FFFF_FFFF);
            end
        endcase
        // Stores only define sizes 000-011; loads reject the single unused code.
        access_fault = (mem_read & mem_write) | addr_misaligned
                     | (mem_write ? funct3[2] : (funct3 == F3_INVALID));
        wstrb_c = size_strb << offset;
        wdata_c = (store_data_in & size_mask) << {offset, 3'b000};
    end

    load_formatter #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_load_formatter (
        .resp_data(resp_data),
        .offset   (offset_q),
        .funct3   (funct3_q),
        .result   (fmt_data)
    );

    // Access FSM with registered request fields and captured load data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            req_valid   <= 1'b0;
            req_addr    <= '0;
            req_wdata   <= '0;
            req_write   <= 1'b0;
            req_wstrb   <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
            load_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem_op && !access_fault) begin
                        req_valid   <= 1'b1;
                        req_addr    <= {alu_in[DATA_WIDTH-1:3], 3'b000};
                        req_write   <= mem_write;
                        req_wstrb   <= mem_write ? wstrb_c : '0;
                        req_wdata   <= mem_write ? wdata_c : '0;
                        funct3_q    <= funct3;
                        offset_q    <= offset;
                        load_data_q <= '0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        req_valid <= 1'b0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_valid) begin
                        load_data_q <= req_write ? '0 : fmt_data;
                        state       <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage outputs follow the slot directly; while stalled MEM/WB sees a bubble.
    always_comb begin
        stall_out      = 1'b0;
        misalign_out   = 1'b0;
        alu_out        = alu_in;
        dest_out       = dest_in;
        mem_data_out   = '0;
        wb_control_out = '0;
        if (reset) begin
            alu_out  = '0;
            dest_out = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem_op) begin
                        misalign_out = access_fault;
                        stall_out    = !access_fault;
                    end else begin
                        wb_control_out = valid_in ? wb_control_in : '0;
                    end
                end
                REQ, WAIT: stall_out = 1'b1;
                DONE: begin
                    mem_data_out   = load_data_q;
                    wb_control_out = valid_in ? wb_control_in : '0;
                end
                default: stall_out = 1'b0;
            endcase
        end
    end

endmodule
